vortex_wrapper_no_vortex: RTL and testbench



---
 rtl/vortex_wrapper_no_vortex.sv | 249 ++++++++++++++++++++++++
 tb/tb_vortex_wrapper_no_vortex.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vortex_wrapper_no_vortex.sv
// Memory/control shell around an external Vortex core: line SRAM,
// AHB line splitter, host SRAM window and control/status registers.
module vortex_wrapper_no_vortex #(
  parameter logic [31:0] LOCAL_BASE = 32'hF000_0000,
  parameter int          MEM_LINES  = 16
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         Vortex_mem_req_valid,
  input  logic         Vortex_mem_req_rw,
  input  logic [63:0]  Vortex_mem_req_byteen,
  input  logic [25:0]  Vortex_mem_req_addr,
  input  logic [511:0] Vortex_mem_req_data,
  input  logic [55:0]  Vortex_mem_req_tag,
  output logic         Vortex_mem_req_ready,
  output logic         Vortex_mem_rsp_valid,
  output logic [511:0] Vortex_mem_rsp_data,
  output logic [55:0]  Vortex_mem_rsp_tag,
  input  logic         Vortex_mem_rsp_ready,
  input  logic         mem_slave_wen,
  input  logic         mem_slave_ren,
  input  logic [31:0]  mem_slave_addr,
  input  logic [31:0]  mem_slave_wdata,
  input  logic [3:0]   mem_slave_strobe,
  output logic [31:0]  mem_slave_rdata,
  output logic         mem_slave_error,
  output logic         mem_slave_request_stall,
  input  logic         ctrl_status_wen,
  input  logic         ctrl_status_ren,
  input  logic [31:0]  ctrl_status_addr,
  input  logic [31:0]  ctrl_status_wdata,
  input  logic [3:0]   ctrl_status_strobe,
  output logic [31:0]  ctrl_status_rdata,
  output logic         ctrl_status_error,
  output logic         ctrl_status_request_stall,
  output logic         ahb_hsel,
  output logic         ahb_hwrite,
  output logic [1:0]   ahb_htrans,
  output logic [2:0]   ahb_hburst,
  output logic [2:0]   ahb_hsize,
  output logic         ahb_hmastlock,
  output logic [31:0]  ahb_haddr,
  output logic [31:0]  ahb_hwdata,
  output logic [3:0]   ahb_hwstrb,
  input  logic         ahb_hready,
  input  logic [31:0]  ahb_hrdata,
  input  logic         ahb_hresp,
  input  logic         Vortex_busy,
  output logic         Vortex_reset,
  output logic         Vortex_PC_reset_val
);
  localparam int LB = $clog2(MEM_LINES);
  localparam int WB = LB + 4;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [2:0] {IDLE, LOCAL, AHB_ADDR, AHB_DATA, RSP} state_t;

  state_t         state;
  logic           rw_q;
  logic [25:0]    addr_q;
  logic [63:0]    byteen_q;
  logic [511:0]   line_q;
  logic [55:0]    tag_q;
  logic [3:0]     beat;
  logic [3:0]     beat_n;
  logic           req_ready_q;
  logic           rsp_valid_q;
  logic           hsel_q;
  logic [1:0]     htrans_q;
  logic           hwrite_q;
  logic [31:0]    haddr_q;
  logic [31:0]    hwdata_q;
  logic [3:0]     hwstrb_q;
  logic           sticky_err;
  logic           vreset_q;
  logic           pcsel_q;
  logic [511:0]   mem [MEM_LINES];

  logic           req_hit;
  logic [LB-1:0]  lidx;
  logic [WB-1:0]  widx;
  logic [LB-1:0]  hline;
  logic [3:0]     hword;
  logic           host_oor;
  logic [1:0]     coff;
  logic           clr_err;
  logic           unused_ok;

  assign req_hit  = Vortex_mem_req_addr[25:LB] == LOCAL_BASE[31:LB+6];
  assign lidx     = addr_q[LB-1:0];
  assign beat_n   = beat + 4'd1;
  assign widx     = mem_slave_addr[WB+1:2];
  assign hline    = widx[WB-1:4];
  assign hword    = widx[3:0];
  assign host_oor = mem_slave_addr >= 32'(MEM_LINES * 64);
  assign coff     = ctrl_status_addr[3:2];
  assign clr_err  = ctrl_status_wen && coff == 2'd1
                 && ctrl_status_strobe[0] && ctrl_status_wdata[2];

  assign Vortex_mem_req_ready = req_ready_q;
  assign Vortex_mem_rsp_valid = rsp_valid_q;
  assign Vortex_mem_rsp_data  = line_q;
  assign Vortex_mem_rsp_tag   = tag_q;
  assign Vortex_reset         = vreset_q;
  assign Vortex_PC_reset_val  = pcsel_q;

  assign ahb_hsel      = hsel_q;
  assign ahb_hwrite    = hwrite_q;
  assign ahb_htrans    = htrans_q;
  assign ahb_hburst    = 3'b000;
  assign ahb_hsize     = 3'b010;
  assign ahb_hmastlock = 1'b0;
  assign ahb_haddr     = haddr_q;
  assign ahb_hwdata    = hwdata_q;
  assign ahb_hwstrb    = hwstrb_q;

  // The FSM owns the SRAM port while in LOCAL; host waits it out
  assign mem_slave_request_stall = state == LOCAL;
  assign mem_slave_error = (mem_slave_wen || mem_slave_ren) && host_oor;
  assign mem_slave_rdata = (mem_slave_ren && !host_oor)
                         ? mem[hline][32*hword +: 32] : '0;

  assign ctrl_status_error = (ctrl_status_wen || ctrl_status_ren) && coff[1];
  assign ctrl_status_request_stall = 1'b0;

  always_comb begin
    ctrl_status_rdata = '0;
    if (ctrl_status_ren) begin
      unique case (1'b1)
        coff == 2'd0: ctrl_status_rdata = {30'd0, pcsel_q, vreset_q};
        coff == 2'd1: ctrl_status_rdata = {29'd0, sticky_err,
                                           state != IDLE, Vortex_busy};
        default:      ctrl_status_rdata = '0;
      endcase
    end
  end

  assign unused_ok = ^{ctrl_status_addr[31:4], ctrl_status_addr[1:0],
                       ctrl_status_wdata[31:3], ctrl_status_strobe[3:1],
                       mem_slave_addr[1:0]};

  always_ff @(posedge clk) begin
    if (state == LOCAL) begin
      if (rw_q) begin
        for (int i = 0; i < 64; i++)
          if (byteen_q[i]) mem[lidx][8*i +: 8] <= line_q[8*i +: 8];
      end
    end else if (mem_slave_wen && !host_oor) begin
      for (int b = 0; b < 4; b++)
        if (mem_slave_strobe[b])
          mem[hline][32*hword + 8*b +: 8] <= mem_slave_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      vreset_q <= 1'b1;
      pcsel_q  <= 1'b0;
    end else if (ctrl_status_wen && coff == 2'd0 && ctrl_status_strobe[0]) begin
      vreset_q <= ctrl_status_wdata[0];
      pcsel_q  <= ctrl_status_wdata[1];
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      byteen_q    <= '0;
      line_q      <= '0;
      tag_q       <= '0;
      beat        <= '0;
      hsel_q      <= 1'b0;
      htrans_q    <= HT_IDLE;
      hwrite_q    <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      hwstrb_q    <= '0;
      sticky_err  <= 1'b0;
    end else begin
      if (clr_err) sticky_err <= 1'b0;
      if (state == AHB_DATA && ahb_hresp) sticky_err <= 1'b1;
      unique case (state)
        IDLE: if (Vortex_mem_req_valid) begin
          rw_q        <= Vortex_mem_req_rw;
          addr_q      <= Vortex_mem_req_addr;
          byteen_q    <= Vortex_mem_req_byteen;
          line_q      <= Vortex_mem_req_data;
          tag_q       <= Vortex_mem_req_tag;
          beat        <= '0;
          req_ready_q <= 1'b0;
          if (req_hit) begin
            state <= LOCAL;
          end else begin
            state    <= AHB_ADDR;
            hsel_q   <= 1'b1;
            htrans_q <= HT_NONSEQ;
            hwrite_q <= Vortex_mem_req_rw;
            haddr_q  <= {Vortex_mem_req_addr, 6'b0};
          end
        end
        LOCAL: begin
          if (rw_q) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            line_q      <= mem[lidx];
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end
        end
        AHB_ADDR: begin
          htrans_q <= HT_IDLE;
          hwdata_q <= line_q[32*beat +: 32];
          hwstrb_q <= byteen_q[4*beat +: 4];
          state    <= AHB_DATA;
        end
        AHB_DATA: if (ahb_hready) begin
          if (!rw_q) line_q[32*beat +: 32] <= ahb_hrdata;
          if (beat == 4'd15) begin
            hsel_q <= 1'b0;
            if (rw_q) begin
              state       <= IDLE;
              req_ready_q <= 1'b1;
            end else begin
              state       <= RSP;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            beat     <= beat_n;
            htrans_q <= HT_NONSEQ;
            haddr_q  <= {addr_q, beat_n, 2'b00};
            state    <= AHB_ADDR;
          end
        end
        RSP: if (Vortex_mem_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vortex_wrapper_no_vortex.sv
// Directed + random bench for vortex_wrapper_no_vortex with an AHB
// slave model and word-level reference memories.
module tb_vortex_wrapper_no_vortex;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 0, req_rw = 0;
  logic [63:0]  req_be = '0;
  logic [25:0]  req_addr = '0;
  logic [511:0] req_data = '0;
  logic [55:0]  req_tag = '0;
  logic         req_ready, rsp_valid;
  logic [511:0] rsp_data;
  logic [55:0]  rsp_tag;
  logic         rsp_ready = 0;
  logic         m_wen = 0, m_ren = 0;
  logic [31:0]  m_addr = '0, m_wdata = '0;
  logic [3:0]   m_strb = '0;
  logic [31:0]  m_rdata;
  logic         m_err, m_stall;
  logic         c_wen = 0, c_ren = 0;
  logic [31:0]  c_addr = '0, c_wdata = '0;
  logic [3:0]   c_strb = '0;
  logic [31:0]  c_rdata;
  logic         c_err, c_stall;
  logic         hsel, hwrite, hmastlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst, hsize;
  logic [31:0]  haddr, hwdata;
  logic [3:0]   hwstrb;
  logic         hready = 1;
  logic [31:0]  hrdata = '0;
  logic         hresp = 0;
  logic         busy = 0;
  logic         vreset, pcval;

  vortex_wrapper_no_vortex dut (
    .clk(clk), .nRST(nRST),
    .Vortex_mem_req_valid(req_valid), .Vortex_mem_req_rw(req_rw),
    .Vortex_mem_req_byteen(req_be), .Vortex_mem_req_addr(req_addr),
    .Vortex_mem_req_data(req_data), .Vortex_mem_req_tag(req_tag),
    .Vortex_mem_req_ready(req_ready), .Vortex_mem_rsp_valid(rsp_valid),
    .Vortex_mem_rsp_data(rsp_data), .Vortex_mem_rsp_tag(rsp_tag),
    .Vortex_mem_rsp_ready(rsp_ready),
    .mem_slave_wen(m_wen), .mem_slave_ren(m_ren), .mem_slave_addr(m_addr),
    .mem_slave_wdata(m_wdata), .mem_slave_strobe(m_strb),
    .mem_slave_rdata(m_rdata), .mem_slave_error(m_err),
    .mem_slave_request_stall(m_stall),
    .ctrl_status_wen(c_wen), .ctrl_status_ren(c_ren),
    .ctrl_status_addr(c_addr), .ctrl_status_wdata(c_wdata),
    .ctrl_status_strobe(c_strb), .ctrl_status_rdata(c_rdata),
    .ctrl_status_error(c_err), .ctrl_status_request_stall(c_stall),
    .ahb_hsel(hsel), .ahb_hwrite(hwrite), .ahb_htrans(htrans),
    .ahb_hburst(hburst), .ahb_hsize(hsize), .ahb_hmastlock(hmastlock),
    .ahb_haddr(haddr), .ahb_hwdata(hwdata), .ahb_hwstrb(hwstrb),
    .ahb_hready(hready), .ahb_hrdata(hrdata), .ahb_hresp(hresp),
    .Vortex_busy(busy), .Vortex_reset(vreset), .Vortex_PC_reset_val(pcval)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // AHB slave model: random wait states, byte-strobed memory
  logic [31:0] slave_mem [int unsigned];
  logic [31:0] seen_addr [$];
  logic        seen_write [$];
  logic [3:0]  seen_strb [$];
  logic [2:0]  seen_size [$];
  bit          beat_mode = 0;
  int          err_beat = -1;
  bit          pending = 0;
  int          waits = 0;
  logic [31:0] cur_addr;
  logic        cur_write;

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : def_word(a);
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    if (!nRST) pending = 0;
    hresp = 0;
    hrdata = '0;
    if (pending) begin
      if (waits == 0) begin
        hready = 1;
        hresp = err_beat == int'(cur_addr[5:2]);
        if (cur_write) begin
          w = slave_rd(cur_addr);
          for (int b = 0; b < 4; b++)
            if (hwstrb[b]) w[8*b +: 8] = hwdata[8*b +: 8];
          slave_mem[cur_addr] = w;
          seen_strb.push_back(hwstrb);
        end else begin
          hrdata = beat_mode ? 32'(cur_addr[5:2]) : slave_rd(cur_addr);
        end
        pending = 0;
      end else begin
        hready = 0;
        waits--;
      end
    end else begin
      hready = 1;
    end
    if (nRST && hsel && htrans == 2'b10) begin
      cur_addr = haddr;
      cur_write = hwrite;
      seen_addr.push_back(haddr);
      seen_write.push_back(hwrite);
      seen_size.push_back(hsize);
      pending = 1;
      waits = $urandom_range(0, 2);
    end
  end

  // Reference models
  logic [31:0] ahb_ref [int unsigned];
  logic [31:0] loc_ref [256];

  function automatic logic [31:0] ahb_exp(input logic [31:0] a);
    return ahb_ref.exists(a) ? ahb_ref[a] : def_word(a);
  endfunction

  function automatic bit is_local(input logic [25:0] a);
    return a[25:4] == 22'h3C0000;
  endfunction

  function automatic logic [511:0] exp_line(input logic [25:0] a);
    logic [511:0] l;
    for (int i = 0; i < 16; i++)
      if (is_local(a)) l[32*i +: 32] = loc_ref[a[3:0]*16 + i];
      else if (beat_mode) l[32*i +: 32] = i;
      else l[32*i +: 32] = ahb_exp({a, 6'b0} + 32'(4*i));
    return l;
  endfunction

  function automatic void model_write(input logic [25:0] a,
      input logic [63:0] be, input logic [511:0] d);
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      if (is_local(a)) w = loc_ref[a[3:0]*16 + i];
      else w = ahb_exp({a, 6'b0} + 32'(4*i));
      for (int b = 0; b < 4; b++)
        if (be[4*i+b]) w[8*b +: 8] = d[32*i + 8*b +: 8];
      if (is_local(a)) loc_ref[a[3:0]*16 + i] = w;
      else ahb_ref[{a, 6'b0} + 32'(4*i)] = w;
    end
  endfunction

  task automatic host_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    @(negedge clk);
    m_wen = 1; m_addr = a; m_wdata = d; m_strb = s;
    @(negedge clk);
    m_wen = 0;
  endtask

  task automatic host_read(input logic [31:0] a, output logic [31:0] d,
                           output logic e);
    @(negedge clk);
    m_ren = 1; m_addr = a;
    #1;
    d = m_rdata; e = m_err;
    m_ren = 0;
  endtask

  task automatic ctrl_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    @(negedge clk);
    c_wen = 1; c_addr = a; c_wdata = d; c_strb = s;
    @(negedge clk);
    c_wen = 0;
  endtask

  task automatic ctrl_read(input logic [31:0] a, output logic [31:0] d,
                           output logic e);
    @(negedge clk);
    c_ren = 1; c_addr = a;
    #1;
    d = c_rdata; e = c_err;
    c_ren = 0;
  endtask

  task automatic vx_txn(input logic rw, input logic [25:0] a,
      input logic [63:0] be, input logic [511:0] d, input logic [55:0] t,
      output logic [511:0] rd, output logic [55:0] rt);
    int n;
    bit saw;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1; req_rw = rw; req_addr = a; req_be = be;
    req_data = d; req_tag = t;
    @(negedge clk);
    req_valid = 0;
    rd = '0; rt = '0;
    if (rw) begin
      n = 0; saw = 0;
      while (!req_ready && n < 400) begin
        if (rsp_valid) saw = 1;
        @(negedge clk); n++;
      end
      check("wr_done", req_ready, 1'b1);
      check("wr_no_rsp", saw, 1'b0);
    end else begin
      n = 0;
      while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("rd_rsp_valid", rsp_valid, 1'b1);
      rd = rsp_data; rt = rsp_tag;
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
    end
  endtask

  initial begin
    logic [31:0]  d;
    logic         e;
    logic [511:0] rl, el, wd;
    logic [55:0]  rt, tg;
    logic [25:0]  a;
    logic [63:0]  be;
    logic         rw;

    // Reset values
    #12;
    check("rst_vreset", vreset, 1'b1);
    check("rst_pcval", pcval, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_htrans", htrans, 2'b00);
    check("rst_hsel", hsel, 1'b0);
    check("rst_stall", m_stall, 1'b0);
    @(negedge clk);
    nRST = 1;

    // Control / status
    ctrl_write(32'h0, 32'h2, 4'h1);
    check("ctrl_vreset", vreset, 1'b0);
    check("ctrl_pcval", pcval, 1'b1);
    ctrl_write(32'h0, 32'h1, 4'h0);
    check("ctrl_nostrobe", {vreset, pcval}, 2'b01);
    busy = 1;
    ctrl_read(32'h4, d, e);
    check("status_busy", d, 32'h1);
    busy = 0;
    ctrl_read(32'h0, d, e);
    check("ctrl_rd", d, 32'h2);
    ctrl_read(32'h8, d, e);
    check("ctrl_bad_err", e, 1'b1);
    check("ctrl_bad_rdata", d, 32'h0);

    // Local SRAM fill through host window
    for (int w = 0; w < 256; w++) begin
      d = $urandom;
      host_write(32'(4*w), d, 4'hF);
      loc_ref[w] = d;
    end
    host_write(32'h0, 32'hDEADBEEF, 4'hF);
    loc_ref[0] = 32'hDEADBEEF;
    host_write(32'h8, 32'h0000AA00, 4'h2);
    loc_ref[2][15:8] = 8'hAA;
    host_read(32'h8, d, e);
    check("host_strobe", d, loc_ref[2]);
    host_read(32'h400, d, e);
    check("host_oor_err", e, 1'b1);

    // Local read colliding with a host write: FSM wins
    el = exp_line(26'h3C00000);
    @(negedge clk);
    req_valid = 1; req_rw = 0; req_addr = 26'h3C00000; req_tag = 56'h5A;
    @(negedge clk);
    req_valid = 0;
    m_wen = 1; m_addr = 32'h14; m_wdata = 32'h12345678; m_strb = 4'hF;
    #1 check("coll_stall", m_stall, 1'b1);
    @(negedge clk);
    #1 check("coll_stall_rel", m_stall, 1'b0);
    @(negedge clk);
    m_wen = 0;
    check("loc_rsp_valid", rsp_valid, 1'b1);
    check("loc_rsp_w0", rsp_data[31:0], 32'hDEADBEEF);
    check("loc_rsp_line", rsp_data, el);
    check("loc_rsp_tag", rsp_tag, 56'h5A);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    loc_ref[5] = 32'h12345678;

    // AHB read, HRDATA = beat number
    beat_mode = 1;
    seen_addr.delete(); seen_write.delete(); seen_size.delete();
    vx_txn(1'b0, 26'h100, '0, '0, 56'h77, rl, rt);
    beat_mode = 0;
    check("ahb_rd_beats", seen_addr.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < seen_addr.size()) check("ahb_rd_haddr", seen_addr[i], 32'h4000 + 32'(4*i));
    check("ahb_rd_hsize", seen_size[0], 3'b010);
    check("ahb_rd_hwrite", seen_write[15], 1'b0);
    for (int i = 0; i < 16; i++) el[32*i +: 32] = i;
    check("ahb_rd_data", rl, el);
    check("ahb_rd_tag", rt, 56'h77);

    // AHB write with byteen = 0xF
    seen_addr.delete(); seen_write.delete(); seen_strb.delete();
    wd = {16{$urandom}};
    vx_txn(1'b1, 26'h100, 64'hF, wd, 56'h1, rl, rt);
    model_write(26'h100, 64'hF, wd);
    check("ahb_wr_beats", seen_strb.size(), 16);
    check("ahb_wr_hwrite", seen_write[0], 1'b1);
    check("ahb_wr_strb0", seen_strb[0], 4'hF);
    check("ahb_wr_strb1", seen_strb[1], 4'h0);
    check("ahb_wr_strb15", seen_strb[15], 4'h0);
    check("ahb_wr_last", seen_addr[15], 32'h403C);

    // Error response on beat 3
    err_beat = 3;
    vx_txn(1'b0, 26'h101, '0, '0, 56'h3, rl, rt);
    err_beat = -1;
    check("err_rd_data", rl, exp_line(26'h101));
    ctrl_read(32'h4, d, e);
    check("status_sticky", d, 32'h4);
    ctrl_write(32'h4, 32'h4, 4'h1);
    ctrl_read(32'h4, d, e);
    check("status_clear", d, 32'h0);

    // Random mix of local and AHB lines
    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom);
      a = ($urandom & 1) ? 26'h3C00000 | 26'($urandom_range(0, 15))
                         : 26'h100 + 26'($urandom_range(0, 7));
      be = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) wd[32*i +: 32] = $urandom;
      tg = {$urandom, $urandom};
      el = exp_line(a);
      seen_addr.delete();
      vx_txn(rw, a, be, wd, tg, rl, rt);
      if (rw) begin
        model_write(a, be, wd);
      end else begin
        check("rnd_rd_data", rl, el);
        check("rnd_rd_tag", rt, tg);
      end
      if (!is_local(a)) check("rnd_ahb_beats", seen_addr.size(), 16);
    end

    for (int w = 0; w < 256; w++) begin
      host_read(32'(4*w), d, e);
      check("sram_final", d, loc_ref[w]);
    end

    // Reset in the middle of an AHB read
    @(negedge clk);
    req_valid = 1; req_rw = 0; req_addr = 26'h102; req_tag = 56'h9;
    @(negedge clk);
    req_valid = 0;
    repeat (6) @(negedge clk);
    nRST = 0;
    #1;
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_htrans", htrans, 2'b00);
    check("mid_rst_rsp", rsp_valid, 1'b0);
    check("mid_rst_vreset", vreset, 1'b1);
    @(negedge clk);
    nRST = 1;
    vx_txn(1'b0, 26'h102, '0, '0, 56'hB, rl, rt);
    check("post_rst_data", rl, exp_line(26'h102));
    check("post_rst_tag", rt, 56'hB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
